// File: rtl/csa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : csa_pkg                                                          |
// | Brief   : Shared helpers and types for the pipelined carry-select adder.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package csa_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int calc_nblk(input int width, input int blk);
        return ceil_div(width, blk);
    endfunction

    function automatic int calc_nstg(input int width, input int blk, input int bps);
        return ceil_div(ceil_div(width, blk), bps);
    endfunction

    // Carry handed from one stage to the next; cmsb is only meaningful in the last stage
    typedef struct packed {
        logic carry;
        logic cmsb;
    } stg_carry_t;

endpackage
`default_nettype wire

// File: rtl/csa_sel_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : csa_sel_block                                                    |
// | Brief   : Carry-select block: both carry hypotheses summed, cin picks one. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module csa_sel_block
    import csa_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_s0;
    logic [W:0] w_s1;

    assign w_s0 = {1'b0, i_a} + {1'b0, i_b};
    assign w_s1 = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, 1'b1};

    assign {o_cout, o_sum} = i_cin ? w_s1 : w_s0;

endmodule
`default_nettype wire

// File: rtl/csa_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : csa_pipe_adder                                                   |
// | Brief   : Pipelined carry-select adder/subtractor, valid/ready streaming.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int BLK          = 4,
    parameter int BLKS_PER_STG = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int c_NBLK   = calc_nblk(WIDTH, BLK);
    localparam int c_NSTG   = calc_nstg(WIDTH, BLK, BLKS_PER_STG);
    localparam int c_LAST_W = WIDTH - (c_NBLK - 1) * BLK;
    localparam logic [WIDTH-1:0] c_ONES = '1;

    logic             w_adv;
    logic             w_vin  [c_NSTG];
    logic [WIDTH-1:0] w_sa   [c_NSTG];
    logic [WIDTH-1:0] w_sb   [c_NSTG];
    logic [WIDTH-1:0] w_ss   [c_NSTG];
    logic             w_sc   [c_NSTG];
    logic [WIDTH-1:0] w_nsum [c_NSTG];
    stg_carry_t       w_ncar [c_NSTG];
    logic [WIDTH-1:0] w_blk_sum;
    logic             w_bcout [c_NBLK];
    logic             w_cmsb;

    logic             r_vld [c_NSTG];
    logic [WIDTH-1:0] r_sum [c_NSTG];
    logic [WIDTH-1:0] r_a   [c_NSTG];
    logic [WIDTH-1:0] r_b   [c_NSTG];
    stg_carry_t       r_car [c_NSTG];

    assign w_adv   = !o_valid || i_ready;
    assign o_ready = w_adv;

    for (genvar s = 0; s < c_NSTG; s++) begin : g_stg
        localparam int c_B_LO   = s * BLKS_PER_STG;
        localparam int c_B_HI   = (((s + 1) * BLKS_PER_STG < c_NBLK) ? (s + 1) * BLKS_PER_STG : c_NBLK) - 1;
        localparam int c_BIT_LO = c_B_LO * BLK;
        localparam int c_BIT_HI = (c_B_HI == c_NBLK - 1) ? WIDTH - 1 : (c_B_HI + 1) * BLK - 1;
        localparam logic [WIDTH-1:0] c_MASK = (c_ONES >> (WIDTH - 1 - c_BIT_HI)) & (c_ONES << c_BIT_LO);

        if (s == 0) begin : g_first
            assign w_vin[s] = i_valid;
            assign w_sa[s]  = i_add_term1;
            assign w_sb[s]  = i_sub ? ~i_add_term2 : i_add_term2;
            assign w_sc[s]  = i_sub | i_cin;
            assign w_ss[s]  = '0;
        end else begin : g_next
            assign w_vin[s] = r_vld[s-1];
            assign w_sa[s]  = r_a[s-1];
            assign w_sb[s]  = r_b[s-1];
            assign w_sc[s]  = r_car[s-1].carry;
            assign w_ss[s]  = r_sum[s-1];
        end

        // Splice this stage's freshly computed slice over the slices from earlier stages
        assign w_nsum[s] = (w_ss[s] & ~c_MASK) | (w_blk_sum & c_MASK);
        assign w_ncar[s] = {w_bcout[c_B_HI], (s == c_NSTG - 1) ? w_cmsb : 1'b0};
    end

    for (genvar b = 0; b < c_NBLK; b++) begin : g_blk
        localparam int c_S  = b / BLKS_PER_STG;
        localparam int c_LO = b * BLK;
        localparam int c_W  = (b == c_NBLK - 1) ? c_LAST_W : BLK;

        logic w_cin;

        if (b % BLKS_PER_STG == 0) begin : g_cin_stg
            assign w_cin = w_sc[c_S];
        end else begin : g_cin_chain
            assign w_cin = w_bcout[b-1];
        end

        if (b == 0) begin : g_ripple
            assign {w_bcout[b], w_blk_sum[c_LO +: c_W]} = {1'b0, w_sa[c_S][c_LO +: c_W]}
                                                        + {1'b0, w_sb[c_S][c_LO +: c_W]}
                                                        + {{c_W{1'b0}}, w_cin};
        end else begin : g_sel
            csa_sel_block #(
                .W (c_W)
            ) u_blk (
                .i_a    (w_sa[c_S][c_LO +: c_W]),
                .i_b    (w_sb[c_S][c_LO +: c_W]),
                .i_cin  (w_cin),
                .o_sum  (w_blk_sum[c_LO +: c_W]),
                .o_cout (w_bcout[b])
            );
        end
    end

    // Carry into the MSB recovered from the MSB's own sum bit and operands
    assign w_cmsb = w_blk_sum[WIDTH-1] ^ w_sa[c_NSTG-1][WIDTH-1] ^ w_sb[c_NSTG-1][WIDTH-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < c_NSTG; s++) begin
                r_vld[s] <= 1'b0;
                r_sum[s] <= '0;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_car[s] <= '0;
            end
        end else if (w_adv) begin
            for (int s = 0; s < c_NSTG; s++) begin
                r_vld[s] <= w_vin[s];
                r_sum[s] <= w_nsum[s];
                r_a[s]   <= w_sa[s];
                r_b[s]   <= w_sb[s];
                r_car[s] <= w_ncar[s];
            end
        end
    end

    assign o_valid = r_vld[c_NSTG-1];
    assign o_sum   = r_sum[c_NSTG-1];
    assign o_cout  = r_car[c_NSTG-1].carry;
    assign o_ovf   = r_car[c_NSTG-1].cmsb ^ r_car[c_NSTG-1].carry;

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_csa_pipe_adder                                                |
// | Brief   : Self-checking bench for csa_pipe_adder at several configurations.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_csa_pipe_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        su;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [9] = '{
        '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
        '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
        '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
        '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0},
        '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
        '{32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1}
    };

    int c_LAT [3] = '{4, 8, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin, sub;
    logic        v [3], rdy [3], o_r [3], o_v [3], o_c [3], o_o [3];
    logic [31:0] o_s [3];

    logic        v25, cin25, sub25, rdy25, o_r25, o_v25, o_c25, o_o25;
    logic [24:0] a25, b25, o_s25;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          bp = 1'b0;
    bit [3:0]    pat = 4'b1001;
    logic [33:0] exp_q [3][$];
    int          n_in [3];
    int          n_out [3];
    bit          held [3];
    logic [34:0] held_val [3];

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(32), .BLK(4), .BLKS_PER_STG(2)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[0]), .o_ready(o_r[0]),
        .i_add_term1(a), .i_add_term2(b), .i_cin(cin), .i_sub(sub),
        .o_valid(o_v[0]), .i_ready(rdy[0]), .o_sum(o_s[0]), .o_cout(o_c[0]), .o_ovf(o_o[0]));

    csa_pipe_adder #(.WIDTH(32), .BLK(4), .BLKS_PER_STG(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[1]), .o_ready(o_r[1]),
        .i_add_term1(a), .i_add_term2(b), .i_cin(cin), .i_sub(sub),
        .o_valid(o_v[1]), .i_ready(rdy[1]), .o_sum(o_s[1]), .o_cout(o_c[1]), .o_ovf(o_o[1]));

    csa_pipe_adder #(.WIDTH(32), .BLK(4), .BLKS_PER_STG(8)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[2]), .o_ready(o_r[2]),
        .i_add_term1(a), .i_add_term2(b), .i_cin(cin), .i_sub(sub),
        .o_valid(o_v[2]), .i_ready(rdy[2]), .o_sum(o_s[2]), .o_cout(o_c[2]), .o_ovf(o_o[2]));

    csa_pipe_adder #(.WIDTH(25), .BLK(4), .BLKS_PER_STG(2)) u_dut25 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v25), .o_ready(o_r25),
        .i_add_term1(a25), .i_add_term2(b25), .i_cin(cin25), .i_sub(sub25),
        .o_valid(o_v25), .i_ready(rdy25), .o_sum(o_s25), .o_cout(o_c25), .o_ovf(o_o25));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic su);
        logic [31:0] yy;
        logic        c0;
        logic [32:0] full;
        logic [31:0] low;
        yy   = su ? ~y : y;
        c0   = su | ci;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, c0};
        low  = {1'b0, x[30:0]} + {1'b0, yy[30:0]} + {31'd0, c0};
        return {low[31] ^ full[32], full[32], full[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bp) rdy[0] = pat[cyc % 4];
    endtask

    task automatic set_v(input logic val);
        for (int k = 0; k < 3; k++) v[k] = val;
    endtask

    task automatic rand_ops();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard: expectation pushed on input handshake, compared on output handshake
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                n_in[k] -= exp_q[k].size();
                exp_q[k].delete();
                held[k] = 1'b0;
            end else begin
                if (held[k])
                    check_val("stall_hold", {o_v[k], o_o[k], o_c[k], o_s[k]}, held_val[k]);
                held[k] = 1'b0;
                if (o_v[k] && rdy[k]) begin
                    if (exp_q[k].size() == 0)
                        check_val("spurious_out", 64'(o_v[k]), 64'd0);
                    else
                        check_val($sformatf("result_dut%0d", k), {o_o[k], o_c[k], o_s[k]}, exp_q[k].pop_front());
                    n_out[k]++;
                end else if (o_v[k]) begin
                    held[k]     = 1'b1;
                    held_val[k] = {1'b1, o_o[k], o_c[k], o_s[k]};
                end
                if (v[k] && o_r[k]) begin
                    exp_q[k].push_back(model(a, b, cin, sub));
                    n_in[k]++;
                end
            end
        end
    end

    initial begin
        int  lat [3];
        int  lat25;
        int  saved;
        bit  got;
        bit  acc;
        logic [24:0] ta [2];
        logic [24:0] tb [2];
        logic        tc [2];
        logic [26:0] te [2];

        for (int k = 0; k < 3; k++) begin
            n_in[k] = 0; n_out[k] = 0; rdy[k] = 1'b1; v[k] = 1'b0; lat[k] = 0;
        end
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        v25 = 1'b0; a25 = '0; b25 = '0; cin25 = 1'b0; sub25 = 1'b0; rdy25 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", 64'(o_v[0]), 64'd0);
        check_val("rst_sum",   64'(o_s[0]), 64'd0);
        check_val("rst_cout",  64'(o_c[0]), 64'd0);
        check_val("rst_ovf",   64'(o_o[0]), 64'd0);
        check_val("rst_valid_all", {o_v[1], o_v[2], o_v25}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency of each pipeline depth
        a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0;
        set_v(1'b1);
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1) set_v(1'b0);
            for (int k = 0; k < 3; k++)
                if (lat[k] == 0 && o_v[k]) lat[k] = t;
        end
        for (int k = 0; k < 3; k++)
            check_val($sformatf("latency_dut%0d", k), 64'(lat[k]), 64'(c_LAT[k]));

        // Hand-computed directed vectors
        for (int i = 0; i < 9; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].ci; sub = vecs[i].su;
            set_v(1'b1);
            tick();
            set_v(1'b0);
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (o_v[0]) begin
                    got = 1'b1;
                    break;
                end
                tick();
            end
            check_val("vec_seen", 64'(got), 64'd1);
            check_val($sformatf("vec%0d", i), {o_o[0], o_c[0], o_s[0]}, {vecs[i].ov, vecs[i].co, vecs[i].s});
            tick();
        end
        repeat (12) tick();

        // Backpressure with i_ready pattern 1,0,0,1
        saved = n_out[0];
        bp = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            v[0] = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                acc = o_r[0];
                tick();
                if (acc) break;
            end
            check_val("bp_accept", 64'(acc), 64'd1);
        end
        v[0] = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (exp_q[0].size() == 0 && !o_v[0]) break;
            tick();
        end
        bp = 1'b0;
        rdy[0] = 1'b1;
        check_val("bp_out_count", 64'(n_out[0] - saved), 64'd8);

        // Reset while the pipeline is full
        tick();
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            v[0] = 1'b1;
            tick();
        end
        check_val("pre_rst_full", 64'(o_v[0]), 64'd1);
        v[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_valid", 64'(o_v[0]), 64'd0);
        saved = n_out[0];
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check_val("no_stale_after_rst", 64'(n_out[0]), 64'(saved));

        // Random stream with bubbles across all pipeline depths
        for (int i = 0; i < 2000; i++) begin
            tick();
            rand_ops();
            set_v(1'($urandom_range(0, 3) != 0));
        end
        tick();
        set_v(1'b0);
        repeat (15) tick();

        // Width with a one-bit remainder block
        ta[0] = 25'h1FF_FFFF; tb[0] = 25'h0; tc[0] = 1'b1; te[0] = {1'b0, 1'b1, 25'h000_0000};
        ta[1] = 25'h0FF_FFFF; tb[1] = 25'h1; tc[1] = 1'b0; te[1] = {1'b1, 1'b0, 25'h100_0000};
        for (int i = 0; i < 2; i++) begin
            a25 = ta[i]; b25 = tb[i]; cin25 = tc[i];
            v25 = 1'b1;
            lat25 = 0;
            for (int t = 1; t <= 20; t++) begin
                tick();
                if (t == 1) v25 = 1'b0;
                if (o_v25) begin
                    lat25 = t;
                    break;
                end
            end
            check_val("w25_latency", 64'(lat25), 64'd4);
            check_val($sformatf("w25_vec%0d", i), {o_o25, o_c25, o_s25}, 64'(te[i]));
            repeat (2) tick();
        end

        for (int k = 0; k < 3; k++)
            check_val($sformatf("inout_count_dut%0d", k), 64'(n_out[k]), 64'(n_in[k]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
